// File: rtl/run_decoder.sv
// Run-length decoder: rebuilds the encoder's do level from r/f strobes,
// measures each run and hands the length out over a valid/ready handshake.
//   clk, rst        : clock, async active-high reset
//   r, f            : run strobe, single-cycle fall strobe
//   len_ready       : consumer accepts len this cycle
//   do_out          : reconstructed do level (high while in RUN)
//   len, len_sat    : completed run length, clamp flag
//   len_valid       : len/len_sat hold an unaccepted result
//   err, err_code   : protocol-violation pulse and its cause
//   ovf             : pulse when a completed result is dropped
module run_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r,
    input  logic             f,
    input  logic             len_ready,
    output logic             do_out,
    output logic [CNT_W-1:0] len,
    output logic             len_sat,
    output logic             len_valid,
    output logic             err,
    output logic [1:0]       err_code,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        TERM,
        ERR
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [1:0] CODE_SPUR_F = 2'd1;
    localparam logic [1:0] CODE_BOTH   = 2'd2;
    localparam logic [1:0] CODE_SEQ    = 2'd3;

    state_t           state, state_n;
    logic [CNT_W-1:0] count, count_n;
    logic             sat, sat_n;
    logic             done;
    logic             viol;
    logic [1:0]       code;

    always_comb begin
        state_n = state;
        count_n = count;
        sat_n   = sat;
        done    = 1'b0;
        viol    = 1'b0;
        code    = err_code;
        unique case (state)
            IDLE: begin
                if (f) begin
                    state_n = ERR;
                    viol    = 1'b1;
                    code    = r ? CODE_BOTH : CODE_SPUR_F;
                end else if (r) begin
                    state_n = RUN;
                    count_n = CNT_ONE;
                    sat_n   = 1'b0;
                end
            end
            RUN: begin
                if (r && f) begin
                    state_n = ERR;
                    viol    = 1'b1;
                    code    = CODE_BOTH;
                end else if (r) begin
                    // Counter clamps at max; one more cycle marks the run as saturated.
                    if (count == CNT_MAX) begin
                        sat_n = 1'b1;
                    end else begin
                        count_n = count + CNT_ONE;
                    end
                end else if (f) begin
                    state_n = TERM;
                    done    = 1'b1;
                end else begin
                    state_n = ERR;
                    viol    = 1'b1;
                    code    = CODE_SEQ;
                end
            end
            TERM: begin
                if (f) begin
                    state_n = ERR;
                    viol    = 1'b1;
                    code    = CODE_SPUR_F;
                end else if (r) begin
                    state_n = ERR;
                    viol    = 1'b1;
                    code    = CODE_SEQ;
                end else begin
                    state_n = IDLE;
                end
            end
            ERR: begin
                // Stay quiet until the line is idle; no new err here.
                if (!r && !f) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (viol) begin
            count_n = '0;
            sat_n   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            sat   <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            sat   <= sat_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            do_out    <= 1'b0;
            len       <= '0;
            len_sat   <= 1'b0;
            len_valid <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'd0;
            ovf       <= 1'b0;
        end else begin
            do_out <= (state_n == RUN);
            err    <= viol;
            ovf    <= 1'b0;
            if (viol) begin
                err_code <= code;
            end
            // A completion may reuse the slot when it is empty or being drained.
            if (done && (!len_valid || len_ready)) begin
                len       <= count;
                len_sat   <= sat;
                len_valid <= 1'b1;
            end else begin
                if (done) begin
                    ovf <= 1'b1;
                end
                if (len_valid && len_ready) begin
                    len_valid <= 1'b0;
                end
            end
        end
    end

endmodule
